// File: rtl/tensor_weight_pkg.sv
// Shared constants, FSM state type and the lane saturation helper for the
// tensor weight join block.
package tensor_weight_pkg;

  localparam int LANE_W = 16;
  localparam int WORD_W = 32;
  localparam int N_LANES = WORD_W / LANE_W;

  // Clamp limits for one signed 16-bit lane.
  localparam logic [LANE_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [LANE_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tw_state_e;

  // Signed saturating add of two lanes. The sum is formed one bit wider; when
  // the top two bits disagree the true result left the 16-bit range, and the
  // top bit tells which rail to clamp to.
  function automatic logic [LANE_W-1:0] sat_add_lane(input logic [LANE_W-1:0] a,
                                                     input logic [LANE_W-1:0] b);
    logic [LANE_W:0]   sum;
    logic [LANE_W-1:0] result;
    sum = {a[LANE_W-1], a} + {b[LANE_W-1], b};
    if (sum[LANE_W] != sum[LANE_W-1]) begin
      result = sum[LANE_W] ? SAT_MIN : SAT_MAX;
    end else begin
      result = sum[LANE_W-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/tw_stream_fifo.sv
// Small show-ahead FIFO for one input stream. The head word is read straight
// from the storage array so a join can consume a word the cycle after it was
// written.
module tw_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses the push even if a pop frees a slot this cycle; this
  // keeps the ack free of any dependency on the join.
  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_reg[rd_ptr_reg];

  // Storage write; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/tensor_weight_join.sv
// Joins two packed-lane input streams pairwise into one output stream of
// lane-wise saturating sums, counted into frames of FRAME_LEN pairs with an
// ap_start/ap_done/ap_idle/ap_ready control handshake.
module tensor_weight_join
  import tensor_weight_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_LEN  = 64
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [WORD_W-1:0] Input_1_V_V,
  input  logic              Input_1_V_V_ap_vld,
  output logic              Input_1_V_V_ap_ack,
  input  logic [WORD_W-1:0] Input_2_V_V,
  input  logic              Input_2_V_V_ap_vld,
  output logic              Input_2_V_V_ap_ack,
  output logic [WORD_W-1:0] Output_1_V_V,
  output logic              Output_1_V_V_ap_vld,
  input  logic              Output_1_V_V_ap_ack
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(FRAME_LEN - 1);

  logic [1:0][WORD_W-1:0] in_word;
  logic [1:0]             in_vld;
  logic [1:0]             in_ack;
  logic [1:0]             fifo_push;
  logic [1:0]             fifo_full;
  logic [1:0]             fifo_empty;
  logic [1:0][WORD_W-1:0] fifo_head;
  logic [WORD_W-1:0]      sum_word;

  tw_state_e              state_reg;
  tw_state_e              state_next;
  logic [CNT_W-1:0]       pair_cnt_reg;
  logic [WORD_W-1:0]      out_data_reg;
  logic                   out_vld_reg;
  logic                   join_fire;
  logic                   last_pair;

  assign in_word[0] = Input_1_V_V;
  assign in_word[1] = Input_2_V_V;
  assign in_vld[0]  = Input_1_V_V_ap_vld;
  assign in_vld[1]  = Input_2_V_V_ap_vld;

  assign Input_1_V_V_ap_ack = in_ack[0];
  assign Input_2_V_V_ap_ack = in_ack[1];

  // A join needs a pair at both heads and a free (or draining) output slot.
  // The output ack only feeds the next register value, never the valid itself.
  assign join_fire = (state_reg == ST_RUN) && !fifo_empty[0] && !fifo_empty[1] &&
                     (!out_vld_reg || Output_1_V_V_ap_ack);
  assign last_pair = (pair_cnt_reg == LAST_PAIR);

  genvar gi;
  generate
    // One buffer per input; inputs are accepted whenever there is room,
    // regardless of FSM state, and never while reset is asserted.
    for (gi = 0; gi < 2; gi++) begin : g_in
      assign in_ack[gi]    = !fifo_full[gi] && !ap_rst;
      assign fifo_push[gi] = in_vld[gi] && in_ack[gi];

      tw_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
      ) u_fifo (
        .clk   (ap_clk),
        .srst  (ap_rst),
        .push  (fifo_push[gi]),
        .pop   (join_fire),
        .din   (in_word[gi]),
        .dout  (fifo_head[gi]),
        .full  (fifo_full[gi]),
        .empty (fifo_empty[gi])
      );
    end

    // Lane-wise saturating adders over the two FIFO heads.
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      assign sum_word[gi*LANE_W +: LANE_W] =
        sat_add_lane(fifo_head[0][gi*LANE_W +: LANE_W], fifo_head[1][gi*LANE_W +: LANE_W]);
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state and control outputs; DONE lasts exactly one cycle.
  always_comb begin
    state_next = state_reg;
    ap_done    = 1'b0;
    ap_idle    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (join_fire && last_pair) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        ap_done    = 1'b1;
        state_next = ap_start ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign ap_ready = ap_done;

  // Pair counter: one step per join, wrapping on the last pair of the frame.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      pair_cnt_reg <= '0;
    end else if (join_fire) begin
      pair_cnt_reg <= last_pair ? '0 : pair_cnt_reg + CNT_W'(1);
    end
  end

  // Output register: loads on a join, holds until acked, so a word still
  // pending when the frame ends survives the DONE cycle.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_data_reg <= '0;
      out_vld_reg  <= 1'b0;
    end else if (join_fire) begin
      out_data_reg <= sum_word;
      out_vld_reg  <= 1'b1;
    end else if (Output_1_V_V_ap_ack) begin
      out_vld_reg  <= 1'b0;
    end
  end

  assign Output_1_V_V        = out_data_reg;
  assign Output_1_V_V_ap_vld = out_vld_reg;

endmodule

// File: tb/tb_tensor_weight_join.sv
// Self-checking bench for tensor_weight_join (FIFO_DEPTH=4, FRAME_LEN=4).
// Expected words come from an arithmetic model of the lane sums applied to the
// words each scenario sends, in send order.
module tb_tensor_weight_join;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [31:0] in1_data;
  logic        in1_vld;
  logic        in1_ack;
  logic [31:0] in2_data;
  logic        in2_vld;
  logic        in2_ack;
  logic [31:0] out_data;
  logic        out_vld;
  logic        out_ack;

  int checks   = 0;
  int failures = 0;

  // Monitor state.
  logic [31:0] obs[$];
  int          obs_cyc[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_at_obs = -1;
  int          ready_viol = 0;
  int          hold_viol = 0;
  bit          prev_pending = 1'b0;
  logic [31:0] prev_data = '0;

  // Words still to be offered on each input.
  logic [31:0] snd1[$];
  logic [31:0] snd2[$];

  always #5 ap_clk = ~ap_clk;

  tensor_weight_join #(
    .FIFO_DEPTH (4),
    .FRAME_LEN  (4)
  ) dut (
    .ap_clk              (ap_clk),
    .ap_rst              (ap_rst),
    .ap_start            (ap_start),
    .ap_done             (ap_done),
    .ap_idle             (ap_idle),
    .ap_ready            (ap_ready),
    .Input_1_V_V         (in1_data),
    .Input_1_V_V_ap_vld  (in1_vld),
    .Input_1_V_V_ap_ack  (in1_ack),
    .Input_2_V_V         (in2_data),
    .Input_2_V_V_ap_vld  (in2_vld),
    .Input_2_V_V_ap_ack  (in2_ack),
    .Output_1_V_V        (out_data),
    .Output_1_V_V_ap_vld (out_vld),
    .Output_1_V_V_ap_ack (out_ack)
  );

  // Reference: each 16-bit lane added as signed integers and clamped.
  function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
    int hi;
    int lo;
    hi = int'($signed(a[31:16])) + int'($signed(b[31:16]));
    lo = int'($signed(a[15:0])) + int'($signed(b[15:0]));
    if (hi > 32767) hi = 32767;
    if (hi < -32768) hi = -32768;
    if (lo > 32767) lo = 32767;
    if (lo < -32768) lo = -32768;
    return {hi[15:0], lo[15:0]};
  endfunction

  // Random word, often with extreme lanes so saturation is exercised.
  function automatic logic [31:0] rand_word();
    logic [15:0] lane [2];
    for (int i = 0; i < 2; i++) begin
      case ($urandom_range(3))
        0:       lane[i] = 16'h7FF0 + 16'($urandom_range(15));
        1:       lane[i] = 16'h8000 + 16'($urandom_range(15));
        default: lane[i] = 16'($urandom);
      endcase
    end
    return {lane[1], lane[0]};
  endfunction

  // Records output handshakes, DONE pulses and protocol violations each cycle.
  always @(negedge ap_clk) begin
    cyc++;
    if (ap_rst) begin
      prev_pending = 1'b0;
    end else begin
      if (prev_pending && (!out_vld || out_data !== prev_data)) hold_viol++;
      if (out_vld && out_ack) begin
        obs.push_back(out_data);
        obs_cyc.push_back(cyc);
      end
      prev_pending = out_vld && !out_ack;
      prev_data    = out_data;
      if (ap_done) begin
        done_cnt++;
        done_at_obs = obs.size();
      end
    end
    if (ap_ready !== ap_done) ready_viol++;
  end

  // One clock of stream driving; called at posedge+1, returns at posedge+1.
  task automatic step(input bit en1, input bit en2, input int ack_mode, input bit gaps);
    in1_vld  = en1 && (snd1.size() > 0) && (!gaps || $urandom_range(3) != 0);
    in1_data = (snd1.size() > 0) ? snd1[0] : 32'h0;
    in2_vld  = en2 && (snd2.size() > 0) && (!gaps || $urandom_range(3) != 0);
    in2_data = (snd2.size() > 0) ? snd2[0] : 32'h0;
    out_ack  = (ack_mode == 2) ? 1'($urandom_range(1)) : (ack_mode != 0);
    @(negedge ap_clk);
    if (in1_vld && in1_ack) void'(snd1.pop_front());
    if (in2_vld && in2_ack) void'(snd2.pop_front());
    @(posedge ap_clk);
    #1;
  endtask

  task automatic run_until(input int n, input int ack_mode, input bit gaps, input int budget);
    int k = 0;
    while (obs.size() < n && k < budget) begin
      step(1'b1, 1'b1, ack_mode, gaps);
      k++;
    end
    in1_vld = 1'b0;
    in2_vld = 1'b0;
    out_ack = 1'b0;
  endtask

  task automatic do_reset();
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    in1_vld  = 1'b0;
    in2_vld  = 1'b0;
    out_ack  = 1'b0;
    repeat (2) begin
      @(posedge ap_clk);
      #1;
    end
    ap_rst = 1'b0;
    snd1.delete();
    snd2.delete();
    obs.delete();
    obs_cyc.delete();
    done_cnt    = 0;
    done_at_obs = -1;
    hold_viol   = 0;
    ready_viol  = 0;
  endtask

  task automatic test_reset();
    ap_rst   = 1'b1;
    ap_start = 1'b1;
    in1_vld  = 1'b1;
    in1_data = 32'h1234_5678;
    in2_vld  = 1'b1;
    in2_data = 32'h0BAD_F00D;
    out_ack  = 1'b0;
    @(posedge ap_clk);
    #1;
    @(negedge ap_clk);
    checks++; if (in1_ack !== 1'b0) begin failures++; $display("FAIL reset_in1_ack got=%b exp=0", in1_ack); end
    checks++; if (in2_ack !== 1'b0) begin failures++; $display("FAIL reset_in2_ack got=%b exp=0", in2_ack); end
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (ap_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", ap_done); end
    checks++; if (ap_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ap_ready); end
    checks++; if (ap_idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", ap_idle); end
    @(posedge ap_clk);
    #1;
    do_reset();
    @(negedge ap_clk);
    checks++; if (in1_ack !== 1'b1) begin failures++; $display("FAIL post_reset_in1_ack got=%b exp=1", in1_ack); end
    @(posedge ap_clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_single_pair();
    do_reset();
    ap_start = 1'b1;
    step(1'b0, 1'b0, 0, 1'b0);
    in1_data = 32'h0001_0002;
    in1_vld  = 1'b1;
    in2_data = 32'h0003_0004;
    in2_vld  = 1'b1;
    @(negedge ap_clk);
    checks++; if (!(in1_ack && in2_ack)) begin failures++; $display("FAIL single_accept got=%b%b exp=11", in1_ack, in2_ack); end
    @(posedge ap_clk);
    #1;
    in1_vld = 1'b0;
    in2_vld = 1'b0;
    @(negedge ap_clk);
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL single_vld_c1 got=%b exp=0", out_vld); end
    @(posedge ap_clk);
    #1;
    @(negedge ap_clk);
    checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL single_vld_c2 got=%b exp=1", out_vld); end
    checks++; if (out_data !== 32'h0004_0006) begin failures++; $display("FAIL single_data got=%h exp=00040006", out_data); end
    @(posedge ap_clk);
    #1;
    out_ack = 1'b1;
    @(posedge ap_clk);
    #1;
    out_ack = 1'b0;
    checks++; if (obs.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", obs.size()); end
    $display("test_single_pair done outputs=%0d", obs.size());
  endtask

  task automatic test_saturation();
    do_reset();
    ap_start = 1'b1;
    snd1.push_back(32'h7FFF_8000);
    snd2.push_back(32'h0001_FFFF);
    run_until(1, 1, 1'b0, 20);
    checks++;
    if (obs.size() != 1) begin
      failures++; $display("FAIL sat_count got=%0d exp=1", obs.size());
    end else if (obs[0] !== 32'h7FFF_8000) begin
      failures++; $display("FAIL sat_data got=%h exp=7fff8000", obs[0]);
    end
    $display("test_saturation done outputs=%0d", obs.size());
  endtask

  task automatic test_backpressure();
    logic [31:0] w1[$];
    logic [31:0] w2[$];
    do_reset();
    ap_start = 1'b1;
    step(1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      w1.push_back(rand_word());
      w2.push_back(rand_word());
    end
    snd1 = w1;
    snd2 = w2;
    repeat (20) step(1'b1, 1'b1, 0, 1'b0);
    checks++; if (6 - snd1.size() != 5) begin failures++; $display("FAIL bp_accept1 got=%0d exp=5", 6 - snd1.size()); end
    checks++; if (6 - snd2.size() != 5) begin failures++; $display("FAIL bp_accept2 got=%0d exp=5", 6 - snd2.size()); end
    checks++; if (in1_ack !== 1'b0 || in2_ack !== 1'b0) begin failures++; $display("FAIL bp_acks got=%b%b exp=00", in1_ack, in2_ack); end
    checks++; if (obs.size() != 0) begin failures++; $display("FAIL bp_no_out got=%0d exp=0", obs.size()); end
    run_until(6, 1, 1'b0, 40);
    checks++; if (obs.size() != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", obs.size()); end
    for (int i = 0; i < obs.size() && i < 6; i++) begin
      checks++;
      if (obs[i] !== ref_sum(w1[i], w2[i])) begin
        failures++; $display("FAIL bp_word[%0d] got=%h exp=%h", i, obs[i], ref_sum(w1[i], w2[i]));
      end
    end
    checks++; if (hold_viol != 0) begin failures++; $display("FAIL bp_hold got=%0d exp=0", hold_viol); end
    $display("test_backpressure done outputs=%0d", obs.size());
  endtask

  task automatic test_frame();
    do_reset();
    ap_start = 1'b1;
    step(1'b0, 1'b0, 1, 1'b0);
    ap_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      snd1.push_back(rand_word());
      snd2.push_back(rand_word());
    end
    run_until(4, 1, 1'b0, 30);
    repeat (3) step(1'b0, 1'b0, 1, 1'b0);
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL frame_done_cnt got=%0d exp=1", done_cnt); end
    checks++; if (done_at_obs != 4) begin failures++; $display("FAIL frame_done_pos got=%0d exp=4", done_at_obs); end
    checks++; if (ready_viol != 0) begin failures++; $display("FAIL frame_ready got=%0d exp=0", ready_viol); end
    checks++; if (ap_idle !== 1'b1) begin failures++; $display("FAIL frame_idle got=%b exp=1", ap_idle); end
    for (int i = 0; i < 2; i++) begin
      snd1.push_back(rand_word());
      snd2.push_back(rand_word());
    end
    repeat (10) step(1'b1, 1'b1, 1, 1'b0);
    checks++; if (obs.size() != 4) begin failures++; $display("FAIL frame_no_join got=%0d exp=4", obs.size()); end
    checks++; if (snd1.size() != 0 || snd2.size() != 0) begin failures++; $display("FAIL frame_idle_accept got=%0d/%0d exp=0/0", snd1.size(), snd2.size()); end
    $display("test_frame done done_cnt=%0d", done_cnt);
  endtask

  task automatic test_skew();
    logic [31:0] w1[$];
    logic [31:0] w2[$];
    do_reset();
    ap_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w1.push_back(rand_word());
      w2.push_back(rand_word());
    end
    snd1 = w1;
    snd2 = w2;
    repeat (10) step(1'b1, 1'b0, 1, 1'b0);
    checks++; if (obs.size() != 0) begin failures++; $display("FAIL skew_early got=%0d exp=0", obs.size()); end
    run_until(4, 1, 1'b0, 40);
    checks++; if (obs.size() != 4) begin failures++; $display("FAIL skew_count got=%0d exp=4", obs.size()); end
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      checks++;
      if (obs[i] !== ref_sum(w1[i], w2[i])) begin
        failures++; $display("FAIL skew_word[%0d] got=%h exp=%h", i, obs[i], ref_sum(w1[i], w2[i]));
      end
    end
    $display("test_skew done outputs=%0d", obs.size());
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1[$];
    logic [31:0] w2[$];
    do_reset();
    ap_start = 1'b1;
    step(1'b0, 1'b0, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      w1.push_back(rand_word());
      w2.push_back(rand_word());
    end
    snd1 = w1;
    snd2 = w2;
    run_until(4, 1, 1'b0, 30);
    checks++; if (obs.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", obs.size()); end
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      checks++;
      if (obs[i] !== ref_sum(w1[i], w2[i])) begin
        failures++; $display("FAIL b2b_word[%0d] got=%h exp=%h", i, obs[i], ref_sum(w1[i], w2[i]));
      end
    end
    for (int i = 1; i < obs_cyc.size() && i < 4; i++) begin
      checks++;
      if (obs_cyc[i] != obs_cyc[0] + i) begin
        failures++; $display("FAIL b2b_rate[%0d] got=%0d exp=%0d", i, obs_cyc[i] - obs_cyc[0], i);
      end
    end
    $display("test_back_to_back done outputs=%0d", obs.size());
  endtask

  task automatic test_random();
    logic [31:0] w1[$];
    logic [31:0] w2[$];
    int          bad = 0;
    do_reset();
    ap_start = 1'b1;
    for (int i = 0; i < 32; i++) begin
      w1.push_back(rand_word());
      w2.push_back(rand_word());
    end
    snd1 = w1;
    snd2 = w2;
    run_until(32, 2, 1'b1, 2000);
    checks++; if (obs.size() != 32) begin failures++; $display("FAIL rand_count got=%0d exp=32", obs.size()); end
    for (int i = 0; i < obs.size() && i < 32; i++) begin
      checks++;
      if (obs[i] !== ref_sum(w1[i], w2[i])) begin
        failures++; bad++;
        if (bad <= 4) $display("FAIL rand_word[%0d] got=%h exp=%h", i, obs[i], ref_sum(w1[i], w2[i]));
      end
    end
    checks++; if (done_cnt != 8) begin failures++; $display("FAIL rand_frames got=%0d exp=8", done_cnt); end
    checks++; if (hold_viol != 0) begin failures++; $display("FAIL rand_hold got=%0d exp=0", hold_viol); end
    checks++; if (ready_viol != 0) begin failures++; $display("FAIL rand_ready got=%0d exp=0", ready_viol); end
    $display("test_random done outputs=%0d frames=%0d", obs.size(), done_cnt);
  endtask

  task automatic test_mid_reset();
    logic [31:0] w1[$];
    logic [31:0] w2[$];
    do_reset();
    ap_start = 1'b1;
    step(1'b0, 1'b0, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      snd1.push_back(rand_word());
      snd2.push_back(rand_word());
    end
    run_until(2, 1, 1'b0, 20);
    repeat (8) step(1'b1, 1'b1, 0, 1'b0);
    checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL mid_pending got=%b exp=1", out_vld); end
    ap_rst  = 1'b1;
    in1_vld = 1'b0;
    in2_vld = 1'b0;
    out_ack = 1'b0;
    @(posedge ap_clk);
    #1;
    @(negedge ap_clk);
    checks++; if (in1_ack !== 1'b0 || in2_ack !== 1'b0) begin failures++; $display("FAIL mid_rst_acks got=%b%b exp=00", in1_ack, in2_ack); end
    checks++; if (out_vld !== 1'b0 || out_data !== 32'h0) begin failures++; $display("FAIL mid_rst_out got=%b/%h exp=0/0", out_vld, out_data); end
    checks++; if (ap_done !== 1'b0 || ap_idle !== 1'b1) begin failures++; $display("FAIL mid_rst_ctrl got=%b%b exp=01", ap_done, ap_idle); end
    @(posedge ap_clk);
    #1;
    do_reset();
    ap_start = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1, 1'b0);
    checks++; if (obs.size() != 0 || out_vld !== 1'b0) begin failures++; $display("FAIL mid_stale got=%0d/%b exp=0/0", obs.size(), out_vld); end
    checks++; if (in1_ack !== 1'b1 || in2_ack !== 1'b1) begin failures++; $display("FAIL mid_empty got=%b%b exp=11", in1_ack, in2_ack); end
    for (int i = 0; i < 4; i++) begin
      w1.push_back(rand_word());
      w2.push_back(rand_word());
    end
    snd1 = w1;
    snd2 = w2;
    run_until(4, 1, 1'b0, 30);
    repeat (2) step(1'b0, 1'b0, 1, 1'b0);
    checks++; if (obs.size() != 4) begin failures++; $display("FAIL mid_count got=%0d exp=4", obs.size()); end
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      checks++;
      if (obs[i] !== ref_sum(w1[i], w2[i])) begin
        failures++; $display("FAIL mid_word[%0d] got=%h exp=%h", i, obs[i], ref_sum(w1[i], w2[i]));
      end
    end
    checks++; if (done_cnt != 1 || done_at_obs != 4) begin failures++; $display("FAIL mid_counter got=%0d@%0d exp=1@4", done_cnt, done_at_obs); end
    $display("test_mid_reset done outputs=%0d", obs.size());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ap_rst   = 1'b0;
    ap_start = 1'b0;
    in1_vld  = 1'b0;
    in1_data = '0;
    in2_vld  = 1'b0;
    in2_data = '0;
    out_ack  = 1'b0;
    #1;
    test_reset();
    test_single_pair();
    test_saturation();
    test_backpressure();
    test_frame();
    test_skew();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tensor_weight_join.md
TENSOR_WEIGHT_JOIN -- requirements
Module: tensor_weight_join

Interface
REQ-001 The block SHALL have one clock, ap_clk, and a synchronous, active-high reset, ap_rst.
REQ-002 FIFO_DEPTH, default 4, SHALL set the per-input buffer depth (power of two, >=2).
REQ-003 FRAME_LEN, default 64, SHALL set the number of joined pairs per frame (>=1).
REQ-004 ap_clk  input  1  user clock.
REQ-005 ap_rst  input  1  synchronous active-high reset.
REQ-006 ap_start  input  1  level; permits frame processing.
REQ-007 ap_done  output  1  one-cycle pulse at frame end.
REQ-008 ap_idle  output  1  high in IDLE state.
REQ-009 ap_ready  output  1  equals ap_done.
REQ-010 Input_1_V_V  input  32  packed word {lane_hi[15:0], lane_lo[15:0]}, signed lanes.
REQ-011 Input_1_V_V_ap_vld  input  1  Input_1 word valid.
REQ-012 Input_1_V_V_ap_ack  output  1  Input_1 word accepted.
REQ-013 Input_2_V_V  input  32  packed word, same format as Input_1.
REQ-014 Input_2_V_V_ap_vld  input  1  Input_2 word valid.
REQ-015 Input_2_V_V_ap_ack  output  1  Input_2 word accepted.
REQ-016 Output_1_V_V  output  32  joined packed word.
REQ-017 Output_1_V_V_ap_vld  output  1  Output word valid.
REQ-018 Output_1_V_V_ap_ack  input  1  downstream accepts word.

Function
REQ-019 A transfer on any stream SHALL occur exactly in a cycle where vld and ack are both high.
REQ-020 Input_n_V_V_ap_ack SHALL equal !full of FIFO n, independent of vld and state; words accepted in any state.
REQ-021 A full FIFO SHALL not accept a push even when popped the same cycle; a non-full FIFO SHALL support simultaneous push and pop.
REQ-022 FSM states: IDLE, RUN, DONE; IDLE->RUN when ap_start=1; RUN->DONE on the join completing pair FRAME_LEN; DONE->RUN if ap_start=1, else IDLE.
REQ-023 A join SHALL fire when state=RUN, both FIFOs non-empty, and (Output vld=0 or Output ack=1); it pops one word from each FIFO and loads the output register.
REQ-024 Output lanes SHALL be lane-wise signed saturating sums: hi=sat(in1_hi+in2_hi), lo=sat(in1_lo+in2_lo), clamp to [-32768, 32767] using 17-bit intermediates.
REQ-025 Output_1_V_V_ap_vld SHALL rise with the loaded word and hold with stable data until acked; no combinational path from Output ack to Output vld.
REQ-026 Input handshake in cycle c SHALL allow Output vld earliest in cycle c+2; sustained throughput SHALL be one word per cycle with Output ack held high.
REQ-027 The pair counter SHALL increment per join, wrap to 0 after FRAME_LEN-1, and assert ap_done during the DONE cycle only.
REQ-028 A word pending in the output register at DONE SHALL remain valid until acked; it SHALL not be dropped.
REQ-029 Pair ordering SHALL be strict FIFO order per input; no reordering or skipping.

Reset
REQ-030 On ap_rst, FIFOs SHALL empty, pair counter=0, state=IDLE; outputs: Input acks=0 during reset cycle, Output vld=0, Output data=0, ap_done=0, ap_ready=0, ap_idle=1.
REQ-031 Reset mid-frame SHALL discard buffered and pending words; operation resumes after deassertion with empty state.

Structure
REQ-032 Package tensor_weight_pkg SHALL hold LANE_W=16, WORD_W=32, SAT_MAX/SAT_MIN constants, and the FSM state enum.
REQ-033 One sub-module, tw_stream_fifo (FIFO_DEPTH x 32, full/empty flags), SHALL be instantiated twice.

Verification
REQ-034 Single pair: In1=0x0001_0002, In2=0x0003_0004 -> Output=0x0004_0006, vld two cycles after last input handshake.
REQ-035 Saturation: In1=0x7FFF_8000, In2=0x0001_FFFF -> Output=0x7FFF_8000.
REQ-036 Backpressure: Output ack=0, push 6 words per input -> Input acks drop after 4 stored + 1 joined; no loss; release yields 6 correct in-order words.
REQ-037 Frame: FRAME_LEN=4, ap_start=1, 4 pairs -> one ap_done/ap_ready pulse after 4th join; ap_start=0 then -> ap_idle=1, no joins.
REQ-038 Skew: In2 words delayed 10 cycles vs In1 -> no output until In2 arrives, then correct pairwise sums.
REQ-039 Mid-frame reset after 2 of 4 pairs with words buffered -> all outputs at reset values, FIFOs empty, counter restarts at 0.
